calc_cmd_loader: RTL and testbench

Byte-stream command front-end for the signed 8-bit calculator. It assembles a 3-byte command frame (header, x, y) from a valid/ready input stream and holds the operands and selector stable on the calculator's inputs. It then samples the calculator's combinational result and presents it on a valid/ready output. It sits directly upstream of, and wraps around, the calculator datapath.

---
 rtl/calc_cmd_loader_if.sv | 23 ++
 rtl/calc_cmd_loader.sv | 69 ++++++
 tb/tb_calc_cmd_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/calc_cmd_loader_if.sv
// calc_cmd_loader_if: byte stream in, calculator operand/result lines, result stream out
interface calc_cmd_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] calc_x;
    logic [7:0] calc_y;
    logic [1:0] calc_sel;
    logic [7:0] calc_out;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] done_count;
    logic       abort;
    modport master (
        output in_data, in_valid, calc_out, res_ready,
        input  in_ready, calc_x, calc_y, calc_sel, res_data, res_valid, done_count, abort
    );
    modport slave (
        input  in_data, in_valid, calc_out, res_ready,
        output in_ready, calc_x, calc_y, calc_sel, res_data, res_valid, done_count, abort
    );
endinterface

// File: rtl/calc_cmd_loader.sv
// calc_cmd_loader: assembles header/x/y frames for the calculator and returns its result.
// Optional mid-frame idle timeout enabled by CALC_LOADER_TIMEOUT_EN.
module calc_cmd_loader #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic rst,
    calc_cmd_loader_if.slave bus
);
    typedef enum logic [2:0] {S_HDR, S_X, S_Y, S_EXEC, S_RES} state_t;
    state_t st;
    logic acc;
    logic timeout;
    assign acc = bus.in_valid && bus.in_ready;
`ifdef CALC_LOADER_TIMEOUT_EN
    logic [7:0] idle;
    logic abort_q;
    assign timeout = (st == S_X || st == S_Y) && !acc && idle == 8'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        idle <= (rst || acc || timeout || !(st == S_X || st == S_Y)) ? 8'd0 : idle + 8'd1;
        abort_q <= !rst && timeout;
    end
    assign bus.abort = abort_q;
`else
    assign timeout = 1'b0;
    // without the timeout the loader can never abort; the parameter keeps its legal range
    assign bus.abort = TIMEOUT_CYCLES < 1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= S_HDR;
            bus.in_ready   <= 1'b1;
            bus.res_valid  <= 1'b0;
            bus.calc_x     <= '0;
            bus.calc_y     <= '0;
            bus.calc_sel   <= '0;
            bus.res_data   <= '0;
            bus.done_count <= '0;
        end else begin
            case (st)
                S_HDR: if (acc && bus.in_data[7:4] == 4'hA) begin
                    bus.calc_sel <= bus.in_data[1:0];
                    st           <= S_X;
                end
                S_X: if (acc) begin
                    bus.calc_x <= bus.in_data;
                    st         <= S_Y;
                end else if (timeout) st <= S_HDR;
                S_Y: if (acc) begin
                    bus.calc_y   <= bus.in_data;
                    bus.in_ready <= 1'b0;
                    st           <= S_EXEC;
                end else if (timeout) st <= S_HDR;
                S_EXEC: begin
                    bus.res_data  <= bus.calc_out;
                    bus.res_valid <= 1'b1;
                    st            <= S_RES;
                end
                S_RES: if (bus.res_ready) begin
                    bus.res_valid  <= 1'b0;
                    bus.in_ready   <= 1'b1;
                    bus.done_count <= bus.done_count + 8'd1;
                    st             <= S_HDR;
                end
                default: st <= S_HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_cmd_loader.sv
// tb_calc_cmd_loader: directed vector table plus corner-case sequences for calc_cmd_loader
module tb_calc_cmd_loader;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [7:0] exp_done = 8'd0;
    calc_cmd_loader_if bus();
    calc_cmd_loader #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // stand-in calculator: add, sub, and, or
    always_comb
        bus.calc_out = bus.calc_sel == 2'd0 ? bus.calc_x + bus.calc_y :
                       bus.calc_sel == 2'd1 ? bus.calc_x - bus.calc_y :
                       bus.calc_sel == 2'd2 ? bus.calc_x & bus.calc_y : bus.calc_x | bus.calc_y;
    typedef struct {
        logic [7:0] h, x, y, r;
        logic [1:0] s;
    } vec_t;
    vec_t tv[5];
    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: byte %0h never accepted", b);
        end
    endtask
    task automatic frame(input logic [7:0] h, x, y, r, input logic [1:0] s);
        push(h);
        push(x);
        push(y);
        check("exec_in_ready", bus.in_ready, 0);
        check("exec_res_valid", bus.res_valid, 0);
        check("calc_y", bus.calc_y, y);
        step();
        check("res_valid", bus.res_valid, 1);
        check("res_data", bus.res_data, r);
        check("calc_x", bus.calc_x, x);
        check("calc_sel", bus.calc_sel, s);
        if (bus.res_ready) begin
            step();
            exp_done++;
            check("post_in_ready", bus.in_ready, 1);
            check("post_res_valid", bus.res_valid, 0);
            check("done_count", bus.done_count, exp_done);
        end
    endtask
    task automatic reset_checks();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_calc_x", bus.calc_x, 0);
        check("rst_calc_y", bus.calc_y, 0);
        check("rst_calc_sel", bus.calc_sel, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_done_count", bus.done_count, 0);
        check("rst_abort", bus.abort, 0);
    endtask
    initial begin
        tv[0] = '{h: 8'hA1, x: 8'hF3, y: 8'hFA, r: 8'hF9, s: 2'd1};
        tv[1] = '{h: 8'hA3, x: 8'h05, y: 8'h02, r: 8'h07, s: 2'd3};
        tv[2] = '{h: 8'hA0, x: 8'h7F, y: 8'h01, r: 8'h80, s: 2'd0};
        tv[3] = '{h: 8'hA2, x: 8'hF0, y: 8'h3C, r: 8'h30, s: 2'd2};
        tv[4] = '{h: 8'hAD, x: 8'h80, y: 8'h01, r: 8'h7F, s: 2'd1};
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        reset_checks();
        for (int i = 0; i < 5; i++) frame(tv[i].h, tv[i].x, tv[i].y, tv[i].r, tv[i].s);
        push(8'h51);
        check("bad_hdr_in_ready", bus.in_ready, 1);
        frame(8'hA3, 8'h05, 8'h02, 8'h07, 2'd3);
        bus.res_ready = 1'b0;
        frame(8'hA0, 8'h40, 8'h40, 8'h80, 2'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_res_valid", bus.res_valid, 1);
            check("bp_res_data", bus.res_data, 8'h80);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.res_ready = 1'b1;
        step();
        exp_done++;
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_res_valid", bus.res_valid, 0);
        check("bp_done_count", bus.done_count, exp_done);
`ifdef CALC_LOADER_TIMEOUT_EN
        push(8'hA2);
        push(8'h10);
        for (int i = 0; i < TO - 1; i++) begin
            step();
            check("to_abort_low", bus.abort, 0);
        end
        step();
        check("to_abort_pulse", bus.abort, 1);
        step();
        check("to_abort_end", bus.abort, 0);
        frame(8'hA0, 8'h11, 8'h22, 8'h33, 2'd0);
`else
        push(8'hA2);
        push(8'h10);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                step();
                seen |= bus.abort;
            end
            check("idle_no_abort", seen, 0);
        end
        push(8'h07);
        check("idle_calc_y", bus.calc_y, 8'h07);
        step();
        check("idle_res_valid", bus.res_valid, 1);
        check("idle_res_data", bus.res_data, 8'h00);
        check("idle_calc_x", bus.calc_x, 8'h10);
        step();
        exp_done++;
        check("idle_done_count", bus.done_count, exp_done);
`endif
        push(8'hA1);
        push(8'h22);
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_checks();
        exp_done = 8'd0;
        frame(8'hA2, 8'h0F, 8'h3C, 8'h0C, 2'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_done = 8'd0;
        for (int i = 0; i < 256; i++) frame(8'hA0, 8'(i), 8'h03, 8'(i + 3), 2'd0);
        check("wrap_done_count", bus.done_count, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
